// File: rtl/video_bus_arbiter_pkg.sv
// Shared types and helpers for the video write-bus arbiter.
package video_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int VID_AW      = 21;
  localparam int FB_ADDR_BIT = VID_AW - 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Frame-buffer select is the top address bit for any address width.
  function automatic int fb_addr_bit(input int aw);
    return aw - 1;
  endfunction

endpackage

// File: rtl/video_bus_arbiter_if.sv
// Requester-side write bundle plus the registered video write bus.
interface video_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = video_arb_pkg::VID_AW,
  parameter int DW   = 32,
  parameter int IDW  = video_arb_pkg::clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fb_gate;
  logic               video_cs;
  logic               video_wr;
  logic [AW-1:0]      video_addr;
  logic [DW-1:0]      video_wr_data;
  logic [IDW-1:0]     grant_id;

  modport master (
    output req_valid, req_lock, req_addr, req_data, fb_gate,
    input  req_ready, video_cs, video_wr, video_addr, video_wr_data, grant_id
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data, fb_gate,
    output req_ready, video_cs, video_wr, video_addr, video_wr_data, grant_id
  );
endinterface

// File: rtl/video_bus_arbiter_rr_priority_picker.sv
// Round-robin picker: first asserted request scanning ptr, ptr+1, ... modulo N.
module rr_priority_picker
  import video_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      idx = sum[IW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/video_bus_arbiter.sv
// Round-robin arbiter with burst lock and frame-buffer write gating onto the
// single registered video write bus.
module video_bus_arbiter
  import video_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = VID_AW,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16,
  parameter int GATE_FB  = 1
) (
  input  logic                clk_sys,
  input  logic                reset_sys_n,
  video_bus_arbiter_if.slave  bus
);

  localparam int IDW    = clog2(NREQ);
  localparam int FB_BIT = fb_addr_bit(AW);

  logic [AW-1:0]   addr_w [NREQ];
  logic [DW-1:0]   data_w [NREQ];
  logic [NREQ-1:0] eligible;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_w[gi]   = bus.req_addr[gi*AW +: AW];
      assign data_w[gi]   = bus.req_data[gi*DW +: DW];
      assign eligible[gi] = bus.req_valid[gi] &&
                            !((GATE_FB != 0) && addr_w[gi][FB_BIT] && !bus.fb_gate);
    end
  endgenerate

  arb_state_t     state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] owner_reg, owner_next;
  logic [7:0]     cnt_reg, cnt_next;
  logic           cs_reg;
  logic [AW-1:0]  addr_reg;
  logic [DW-1:0]  data_reg;
  logic [IDW-1:0] gid_reg;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic [NREQ-1:0] ready;
  logic            accept;
  logic [IDW-1:0]  sel_id;
  logic [8:0]      cnt_inc;

  rr_priority_picker #(.N(NREQ), .IW(IDW)) u_pick (
    .req    (eligible),
    .ptr    (ptr_reg),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
    return (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
  endfunction

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    ready      = '0;
    accept     = 1'b0;
    sel_id     = pick_id;
    cnt_inc    = {1'b0, cnt_reg} + 9'd1;
    case (state_reg)
      ARB: begin
        if (pick_any) begin
          ready  = pick_gnt;
          accept = 1'b1;
          if (bus.req_lock[pick_id] && (LOCK_MAX > 1)) begin
            state_next = LOCK;
            owner_next = pick_id;
            cnt_next   = 8'd1;
          end else begin
            ptr_next = wrap_inc(pick_id);
          end
        end
      end
      LOCK: begin
        sel_id = owner_reg;
        if (eligible[owner_reg]) begin
          ready[owner_reg] = 1'b1;
          accept           = 1'b1;
          // 9-bit compare so a LOCK_MAX of 256 terminates without wrapping.
          if (!bus.req_lock[owner_reg] || (cnt_inc >= 9'(LOCK_MAX))) begin
            ptr_next   = wrap_inc(owner_reg);
            state_next = ARB;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc[7:0];
          end
        end else begin
          // Owner dropped valid or got gated: release the lock, idle one cycle.
          ptr_next   = wrap_inc(owner_reg);
          state_next = ARB;
          cnt_next   = '0;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      state_reg <= ARB;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      cs_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      gid_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      cs_reg    <= accept;
      if (accept) begin
        addr_reg <= addr_w[sel_id];
        data_reg <= data_w[sel_id];
        gid_reg  <= sel_id;
      end
    end
  end

  assign bus.req_ready     = reset_sys_n ? ready : '0;
  assign bus.video_cs      = cs_reg;
  assign bus.video_wr      = cs_reg;
  assign bus.video_addr    = addr_reg;
  assign bus.video_wr_data = data_reg;
  assign bus.grant_id      = gid_reg;

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Directed table-driven bench for video_bus_arbiter plus hand sequences for
// reset behaviour and async reset in the middle of a locked burst.
module tb_video_bus_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 21;
  localparam int DW   = 32;

  logic clk;
  logic rst_n;

  video_bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(2)) bus ();

  video_bus_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(16), .GATE_FB(1)
  ) dut (
    .clk_sys     (clk),
    .reset_sys_n (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] lock;
    logic [3:0] fbm;
    logic       gate;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  logic [AW-1:0] nf_a [NREQ] = '{21'h000008, 21'h000020, 21'h000030, 21'h000010};
  logic [AW-1:0] fb_a [NREQ] = '{21'h100000, 21'h100040, 21'h100080, 21'h1000C0};

  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic [1:0]    last_gid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] valid, input logic [3:0] lock, input logic [3:0] fbm,
                     input logic gate, input logic [3:0] exp_ready);
    vec_t v;
    v.valid = valid; v.lock = lock; v.fbm = fbm; v.gate = gate; v.exp_ready = exp_ready;
    vecs.push_back(v);
  endtask

  function automatic logic [DW-1:0] data_of(input int r, input int tag);
    return 32'hD000_0000 | (32'(r) << 24) | 32'(tag);
  endfunction

  task automatic drive(input logic [3:0] valid, input logic [3:0] lock, input logic [3:0] fbm,
                       input logic gate, input int tag);
    bus.req_valid = valid;
    bus.req_lock  = lock;
    bus.fb_gate   = gate;
    for (int r = 0; r < NREQ; r++) begin
      bus.req_addr[r*AW +: AW] = fbm[r] ? fb_a[r] : nf_a[r];
      bus.req_data[r*DW +: DW] = data_of(r, tag);
    end
  endtask

  initial begin
    // Round robin, all valid, no lock.
    add(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0001);
    add(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0010);
    add(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0100);
    add(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1000);
    add(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0001);
    add(4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0100);
    add(4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001);
    add(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000);
    add(4'b1001, 4'b0000, 4'b0000, 1'b0, 4'b1000);
    // Frame-buffer gating on requester 1.
    add(4'b1010, 4'b0000, 4'b0010, 1'b0, 4'b1000);
    add(4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0000);
    add(4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0010);
    // Requester 2 locks: 16 grants then forced rotation to 3.
    for (int k = 0; k < 16; k++) add(4'b1111, 4'b0100, 4'b0000, 1'b0, 4'b0100);
    add(4'b1111, 4'b0100, 4'b0000, 1'b0, 4'b1000);
    // Requester 0 locks for 5 beats then drops valid.
    for (int k = 0; k < 5; k++) add(4'b1111, 4'b0001, 4'b0000, 1'b0, 4'b0001);
    add(4'b1110, 4'b0001, 4'b0000, 1'b0, 4'b0000);
    add(4'b1110, 4'b0000, 4'b0000, 1'b0, 4'b0010);
    // Lock released by dropping req_lock.
    add(4'b1111, 4'b0100, 4'b0000, 1'b0, 4'b0100);
    add(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0100);
    add(4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1000);
    // fb_gate drops mid-burst on a frame-buffer burst.
    add(4'b0011, 4'b0001, 4'b0001, 1'b1, 4'b0001);
    add(4'b0011, 4'b0001, 4'b0001, 1'b0, 4'b0000);
    add(4'b0011, 4'b0000, 4'b0001, 1'b0, 4'b0010);

    // Reset with all requesters valid.
    rst_n = 1'b0;
    drive(4'b1111, 4'b0000, 4'b0000, 1'b0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    check("rst_cs", 64'(bus.video_cs), 64'h0);
    check("rst_addr", 64'(bus.video_addr), 64'h0);
    check("rst_gid", 64'(bus.grant_id), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    last_addr = '0;
    last_data = '0;
    last_gid  = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      logic exp_cs;
      int   idx;
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].lock, vecs[i].fbm, vecs[i].gate, i);
      #1;
      check($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      exp_cs = |vecs[i].exp_ready;
      if (exp_cs) begin
        idx = 0;
        for (int r = 0; r < NREQ; r++) if (vecs[i].exp_ready[r]) idx = r;
        last_addr = vecs[i].fbm[idx] ? fb_a[idx] : nf_a[idx];
        last_data = data_of(idx, i);
        last_gid  = 2'(idx);
      end
      check($sformatf("v%0d_cs", i), 64'(bus.video_cs), 64'(exp_cs));
      check($sformatf("v%0d_wr", i), 64'(bus.video_wr), 64'(exp_cs));
      check($sformatf("v%0d_addr", i), 64'(bus.video_addr), 64'(last_addr));
      check($sformatf("v%0d_data", i), 64'(bus.video_wr_data), 64'(last_data));
      check($sformatf("v%0d_gid", i), 64'(bus.grant_id), 64'(last_gid));
      $display("[TB] vec %0d valid=%b lock=%b gate=%b ready=%b cs=%b addr=%h gid=%0d",
               i, vecs[i].valid, vecs[i].lock, vecs[i].gate, bus.req_ready,
               bus.video_cs, bus.video_addr, bus.grant_id);
    end

    // Async reset during the third beat of a locked burst by requester 2.
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      drive(4'b0100, 4'b0100, 4'b0000, 1'b0, 100 + b);
      #1;
      check($sformatf("lk_b%0d_ready", b), 64'(bus.req_ready), 64'h4);
      @(posedge clk);
      #1;
      check($sformatf("lk_b%0d_gid", b), 64'(bus.grant_id), 64'h2);
      $display("[TB] lock beat %0d cs=%b gid=%0d", b, bus.video_cs, bus.grant_id);
    end
    @(negedge clk);
    drive(4'b0100, 4'b0100, 4'b0000, 1'b0, 102);
    #1;
    check("lk_b2_ready", 64'(bus.req_ready), 64'h4);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(bus.req_ready), 64'h0);
    check("arst_cs", 64'(bus.video_cs), 64'h0);
    check("arst_addr", 64'(bus.video_addr), 64'h0);
    check("arst_data", 64'(bus.video_wr_data), 64'h0);
    check("arst_gid", 64'(bus.grant_id), 64'h0);
    $display("[TB] async reset mid-burst cs=%b ready=%b", bus.video_cs, bus.req_ready);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'b0000, 4'b0000, 1'b0, 200);
    #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'h1);
    @(posedge clk);
    #1;
    check("post_rst_cs", 64'(bus.video_cs), 64'h1);
    check("post_rst_gid", 64'(bus.grant_id), 64'h0);
    check("post_rst_addr", 64'(bus.video_addr), 64'(nf_a[0]));
    $display("[TB] post reset grant gid=%0d addr=%h", bus.grant_id, bus.video_addr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
